// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the writeback arbiter and related
// register-file logic.
//   RF_ADDR_W     register index width
//   RF_NUM_REGS   number of architectural registers
//   RF_X0         index of the hard-wired zero register
//   rf_wb_state_t writeback arbiter control states
package rf_pkg;

  localparam int unsigned      RF_ADDR_W   = 5;
  localparam int unsigned      RF_NUM_REGS = 32;
  localparam logic [RF_ADDR_W-1:0] RF_X0   = 5'd0;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    SCRUB = 2'd1,
    RUN   = 2'd2
  } rf_wb_state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle between NUM_REQ writeback sources and the
// register-file write-port arbiter.
//   req_valid  per-source write request
//   req_rd     per-source destination index, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   req_data   per-source write data, source i at [i*XLEN +: XLEN]
//   req_ready  one-hot grant back to the sources; transfer when valid & ready
// Modports: master = writeback sources, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]       req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. Searches req starting at ptr, wrapping
// modulo NUM_REQ, and grants the first set bit.
//   req          request vector
//   ptr          highest-priority index this cycle (must be < NUM_REQ)
//   grant        one-hot grant (all zero when nothing requests)
//   grant_idx    encoded index of the granted request
//   grant_valid  1 when any request was granted
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    logic [IDX_W:0] pos;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // ptr + off can exceed NUM_REQ-1 by at most NUM_REQ-1, so a single
      // conditional subtract performs the modulo wrap.
      pos = {1'b0, ptr} + (IDX_W+1)'(off);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_valid && req[pos[IDX_W-1:0]]) begin
        grant[pos[IDX_W-1:0]] = 1'b1;
        grant_idx             = pos[IDX_W-1:0];
        grant_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. Shares the single RegWrite/Rd/Write_data
// port between NUM_REQ writeback sources with round-robin priority and a
// valid/ready handshake per source. The write port is driven from a register,
// one cycle after the accepting edge.
// Optional feature: define RF_WB_SCRUB_EN to zero registers 1..31 after reset
// before any request is accepted.
//   clk            clock, all state on posedge
//   rst            asynchronous active-low reset
//   wb             request bundle (slave side)
//   rf_RegWrite    register file write enable
//   rf_Rd          register file destination index
//   rf_Write_data  register file write data
//   grant_id       source index of the current write (valid with rf_RegWrite)
//   init_done      1 once requests are being accepted
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 3,
  parameter  int unsigned XLEN       = 32,
  parameter  int unsigned REG_ADDR_W = RF_ADDR_W,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_wb_arbiter_if.slave        wb,
  output logic                  rf_RegWrite,
  output logic [REG_ADDR_W-1:0] rf_Rd,
  output logic [XLEN-1:0]       rf_Write_data,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  init_done
);

  rf_wb_state_t state, state_nxt;

  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (wb.req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef RF_WB_SCRUB_EN
  // Counts 1..RF_NUM_REGS: values below RF_NUM_REGS are the index being
  // scrubbed this edge, RF_NUM_REGS means the last scrub write is on the port.
  localparam logic [RF_ADDR_W:0] SCRUB_END = (RF_ADDR_W+1)'(RF_NUM_REGS);
  logic [RF_ADDR_W:0] scrub_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scrub_cnt <= (RF_ADDR_W+1)'(1);
    end else if (state == SCRUB && scrub_cnt != SCRUB_END) begin
      scrub_cnt <= scrub_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wb.req_ready = '0;
    init_done    = 1'b0;
    unique case (state)
      RESET: begin
`ifdef RF_WB_SCRUB_EN
        state_nxt = SCRUB;
`else
        state_nxt = RUN;
`endif
      end
      SCRUB: begin
`ifdef RF_WB_SCRUB_EN
        // Leave only after the rd=31 write has been presented for a cycle.
        if (scrub_cnt == SCRUB_END) begin
          state_nxt = RUN;
        end
`else
        state_nxt = RUN;
`endif
      end
      RUN: begin
        wb.req_ready = grant;
        init_done    = 1'b1;
      end
      default: state_nxt = RESET;
    endcase
  end

  assign accept = (state == RUN) && grant_valid;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rd   = wb.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output stage. rf_Rd/rf_Write_data only change on a real write so the
  // port holds its last value on idle cycles and on suppressed x0 writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_RegWrite   <= 1'b0;
      rf_Rd         <= '0;
      rf_Write_data <= '0;
      grant_id      <= '0;
    end else begin
      rf_RegWrite <= 1'b0;
      unique case (state)
`ifdef RF_WB_SCRUB_EN
        SCRUB: begin
          if (scrub_cnt != SCRUB_END) begin
            rf_RegWrite   <= 1'b1;
            rf_Rd         <= REG_ADDR_W'(scrub_cnt[RF_ADDR_W-1:0]);
            rf_Write_data <= '0;
          end
        end
`endif
        RUN: begin
          if (accept) begin
            grant_id <= grant_idx;
            if (sel_rd != REG_ADDR_W'(RF_X0)) begin
              rf_RegWrite   <= 1'b1;
              rf_Rd         <= sel_rd;
              rf_Write_data <= sel_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter (NUM_REQ=3, XLEN=32).
// Build with or without RF_WB_SCRUB_EN to match the design under test.
module tb_rf_wb_arbiter;

  localparam int unsigned N = 3;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  gid;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rf_RegWrite;
  logic [4:0]  rf_Rd;
  logic [31:0] rf_Write_data;
  logic [1:0]  grant_id;
  logic        init_done;

  int vectors     = 0;
  int miscompares = 0;

  exp_t sb[$];

  // Reference state for the expected-output model.
  logic [1:0]  m_ptr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [1:0]  m_gid;

  rf_wb_arbiter_if #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) wb ();

  rf_wb_arbiter #(
    .NUM_REQ    (3),
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (wb),
    .rf_RegWrite   (rf_RegWrite),
    .rf_Rd         (rf_Rd),
    .rf_Write_data (rf_Write_data),
    .grant_id      (grant_id),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pick(input logic [2:0] v, input logic [1:0] ptr);
    // returns {found, unused, idx}
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (int'(ptr) + k) % 3;
      if (v[p]) return {1'b1, 1'b0, 2'(p)};
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr  = 2'd0;
    m_rd   = 5'd0;
    m_data = 32'd0;
    m_gid  = 2'd0;
    sb.delete();
  endtask

  task automatic check_out(input exp_t e);
    chk({e.tag, "_we"},   64'(rf_RegWrite),   64'(e.we));
    chk({e.tag, "_rd"},   64'(rf_Rd),         64'(e.rd));
    chk({e.tag, "_data"}, 64'(rf_Write_data), 64'(e.data));
    chk({e.tag, "_gid"},  64'(grant_id),      64'(e.gid));
  endtask

  // Starts at posedge+1, ends at the next posedge+1 with that edge's output checked.
  task automatic step(input string tag, input logic [2:0] v,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    logic [3:0]  pick;
    logic [2:0]  exp_ready;
    logic [4:0]  rds [3];
    logic [31:0] ds  [3];
    exp_t        e;
    rds[0] = r0; rds[1] = r1; rds[2] = r2;
    ds[0]  = d0; ds[1]  = d1; ds[2]  = d2;
    wb.req_valid = v;
    wb.req_rd    = {r2, r1, r0};
    wb.req_data  = {d2, d1, d0};
    #1;
    pick      = model_pick(v, m_ptr);
    exp_ready = pick[3] ? 3'(1 << pick[1:0]) : 3'b000;
    chk({tag, "_ready"}, 64'(wb.req_ready), 64'(exp_ready));
    e.tag = tag;
    e.we  = 1'b0;
    if (pick[3]) begin
      m_gid = pick[1:0];
      if (rds[pick[1:0]] != 5'd0) begin
        e.we   = 1'b1;
        m_rd   = rds[pick[1:0]];
        m_data = ds[pick[1:0]];
      end
      m_ptr = (pick[1:0] == 2'd2) ? 2'd0 : pick[1:0] + 2'd1;
    end
    e.rd   = m_rd;
    e.data = m_data;
    e.gid  = m_gid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      check_out(sb.pop_front());
    end
  endtask

  // Called with rst released at a negedge; ends at posedge+1 in the first RUN cycle.
  task automatic post_release(input string tag);
    model_reset();
    #1;
    chk({tag, "_init_pre"}, 64'(init_done), 64'd0);
`ifdef RF_WB_SCRUB_EN
    wb.req_valid = 3'b111;
    wb.req_rd    = {5'd3, 5'd2, 5'd1};
    @(posedge clk);
    #1;
    chk({tag, "_scrub_e0_we"}, 64'(rf_RegWrite), 64'd0);
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_scrub_we"},    64'(rf_RegWrite),   64'd1);
      chk({tag, "_scrub_rd"},    64'(rf_Rd),         64'(i));
      chk({tag, "_scrub_data"},  64'(rf_Write_data), 64'd0);
      chk({tag, "_scrub_ready"}, 64'(wb.req_ready),  64'd0);
      chk({tag, "_scrub_init"},  64'(init_done),     64'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_run_init"}, 64'(init_done),   64'd1);
    chk({tag, "_run_we"},   64'(rf_RegWrite), 64'd0);
    wb.req_valid = 3'b000;
    m_rd = 5'd31;
`else
    @(posedge clk);
    #1;
    chk({tag, "_run_init"}, 64'(init_done),   64'd1);
    chk({tag, "_run_we"},   64'(rf_RegWrite), 64'd0);
`endif
  endtask

  initial begin
    wb.req_valid = '0;
    wb.req_rd    = '0;
    wb.req_data  = '0;
    #3;
    chk("rst_we",    64'(rf_RegWrite),   64'd0);
    chk("rst_rd",    64'(rf_Rd),         64'd0);
    chk("rst_data",  64'(rf_Write_data), 64'd0);
    chk("rst_gid",   64'(grant_id),      64'd0);
    chk("rst_ready", 64'(wb.req_ready),  64'd0);
    chk("rst_init",  64'(init_done),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    post_release("rel1");

    // Single source.
    step("single", 3'b001, 5'd5, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
    chk("single_const_data", 64'(rf_Write_data), 64'h55);
    // Source 2 alone moves the pointer back to 0 (wrap).
    step("wrap", 3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99);

    // All three valid: grants 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      step("rr3", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
      chk("rr3_const_gid", 64'(grant_id), 64'(i % 3));
    end

    // x0 write: accepted, pointer advances, write suppressed.
    step("x0", 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFF, 32'h0);
    chk("x0_const_we", 64'(rf_RegWrite), 64'd0);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    // Pointer is now 2: source 2 wins over source 0.
    step("ptr2", 3'b101, 5'd6, 5'd0, 5'd4, 32'h66, 32'h0, 32'h44);
    chk("ptr2_const_rd", 64'(rf_Rd), 64'd4);

    // Same rd from two sources, pointer 0: 0xA then 0xB.
    step("same_rd_a", 3'b101, 5'd7, 5'd0, 5'd7, 32'hA, 32'h0, 32'hB);
    step("same_rd_b", 3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hB);
    chk("same_rd_final", 64'(rf_Write_data), 64'hB);

    // Mid-stream reset with a write in the output stage.
    step("inflight", 3'b001, 5'd12, 5'd0, 5'd0, 32'hC, 32'h0, 32'h0);
    wb.req_valid = 3'b011;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_we",    64'(rf_RegWrite),   64'd0);
    chk("midrst_rd",    64'(rf_Rd),         64'd0);
    chk("midrst_data",  64'(rf_Write_data), 64'd0);
    chk("midrst_gid",   64'(grant_id),      64'd0);
    chk("midrst_ready", 64'(wb.req_ready),  64'd0);
    chk("midrst_init",  64'(init_done),     64'd0);
    wb.req_valid = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    post_release("rel2");
    // Pointer restarted at 0.
    step("after_rst", 3'b011, 5'd8, 5'd9, 5'd0, 32'h88, 32'h99, 32'h0);
    chk("after_rst_gid", 64'(grant_id), 64'd0);
    step("after_rst2", 3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
